// File: rtl/shared_data_mem.sv
// shared_data_mem: single-port word-wide data memory behind the dual-core arbiter.
// One access at a time. The access is granted, held for a fixed number of wait cycles,
// and answered with read data or a write acknowledge. After the answer there is one
// recover cycle.
//
// Handshake: the memory samples data_req on a rising clk edge while idle. The cycle
// after that edge, data_gnt pulses high for exactly one cycle. After LATENCY wait
// cycles, data_r_valid pulses high for exactly one cycle. On a read, data_read carries
// the word during that pulse. Everywhere else data_read is 0. Requests are ignored
// from the capture edge until the memory is idle again. Dropping data_req after
// capture does not cancel the access.
module shared_data_mem #(
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        res,
    input  logic        data_req,
    input  logic [31:0] data_adr,
    input  logic        data_write_enable,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_write,
    output logic        data_gnt,
    output logic        data_r_valid,
    output logic [31:0] data_read,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;
    // Terminal count of the wait counter. It is unused when LATENCY is 0.
    localparam logic [3:0] WAIT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GNT     = 3'd1,
        S_WAIT    = 3'd2,
        S_RVALID  = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_nxt;
    logic              commit;

    logic [ADDR_W-1:0] cap_idx;
    logic              cap_we;
    logic [3:0]        cap_be;
    logic [31:0]       cap_wdata;

    logic [31:0]       mem [DEPTH];

    // The high address bits wrap the index. The byte-offset bits are ignored.
    logic              unused_adr_bits;
    assign unused_adr_bits = ^{data_adr[31:ADDR_W+2], data_adr[1:0]};

    // Next-state logic and the wait counter. Inputs only matter in IDLE.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (data_req) state_nxt = S_GNT;
            end
            S_GNT: begin
                wait_cnt_nxt = 4'd0;
                state_nxt    = (LATENCY == 0) ? S_RVALID : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt    = S_RVALID;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            S_RVALID:  state_nxt = S_RECOVER;
            // The arbiter's registered req lingers here, so this cycle must not capture it.
            S_RECOVER: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The edge that enters RVALID applies the write or latches the read word.
    assign commit = (state_nxt == S_RVALID);

    // State, capture registers and registered outputs. All are cleared by the async reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            cap_idx      <= '0;
            cap_we       <= 1'b0;
            cap_be       <= 4'd0;
            cap_wdata    <= 32'd0;
            data_gnt     <= 1'b0;
            data_r_valid <= 1'b0;
            data_read    <= 32'd0;
            busy         <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == S_IDLE && data_req) begin
                cap_idx   <= data_adr[ADDR_W+1:2];
                cap_we    <= data_write_enable;
                cap_be    <= data_be;
                cap_wdata <= data_write;
            end
            data_gnt     <= (state_nxt == S_GNT);
            data_r_valid <= commit;
            busy         <= (state_nxt != S_IDLE);
            data_read    <= (commit && !cap_we) ? mem[cap_idx] : 32'd0;
        end
    end

    // Byte-enabled array write on the commit edge. The array is not reset, and a
    // reset before the commit edge keeps the FSM out of RVALID, so no write happens.
    always_ff @(posedge clk) begin
        if (commit && cap_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) mem[cap_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_shared_data_mem.sv
// Bench for shared_data_mem. It runs two instances: u_lat2 (LATENCY=2) and u_lat0 (LATENCY=0).
// A word-array reference model predicts the expected data. A cycle schedule, derived from
// the request-to-r_valid timing, predicts when each output pulses.
module tb_shared_data_mem;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic        req  [2];
    logic [31:0] adr  [2];
    logic        we   [2];
    logic [3:0]  be   [2];
    logic [31:0] wdat [2];
    logic        gnt  [2];
    logic        rv   [2];
    logic [31:0] rdat [2];
    logic        bsy  [2];

    shared_data_mem #(.ADDR_W(ADDR_W), .LATENCY(2)) u_lat2 (
        .clk(clk), .res(res), .data_req(req[0]), .data_adr(adr[0]),
        .data_write_enable(we[0]), .data_be(be[0]), .data_write(wdat[0]),
        .data_gnt(gnt[0]), .data_r_valid(rv[0]), .data_read(rdat[0]), .busy(bsy[0])
    );

    shared_data_mem #(.ADDR_W(ADDR_W), .LATENCY(0)) u_lat0 (
        .clk(clk), .res(res), .data_req(req[1]), .data_adr(adr[1]),
        .data_write_enable(we[1]), .data_be(be[1]), .data_write(wdat[1]),
        .data_gnt(gnt[1]), .data_r_valid(rv[1]), .data_read(rdat[1]), .busy(bsy[1])
    );

    // ---------------- reference model ----------------
    logic [31:0] model_mem [2][DEPTH];
    int          lat_of [2] = '{2, 0};
    int checks = 0;
    int errors = 0;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (new_w & m) | (old_w & ~m);
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One complete access, checking every cycle from grant through the return to idle.
    task automatic access(input int s, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        logic [31:0] exp_rd;
        int          ix;
        ix = idx_of(a);
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; adr[s] = a; be[s] = b; wdat[s] = d;
        @(negedge clk);                       // GNT cycle
        req[s] = 1'b0; we[s] = $urandom_range(0, 1); adr[s] = $urandom;
        be[s] = 4'($urandom); wdat[s] = $urandom;
        chk("gnt_pulse", 32'(gnt[s]), 32'd1);
        chk("gnt_busy", 32'(bsy[s]), 32'd1);
        for (int i = 0; i < lat_of[s]; i++) begin
            @(negedge clk);                   // WAIT cycles
            chk("wait_gnt", 32'(gnt[s]), 32'd0);
            chk("wait_rv", 32'(rv[s]), 32'd0);
        end
        if (w) begin
            model_mem[s][ix] = merge(model_mem[s][ix], d, b);
            exp_rd = 32'd0;
        end else begin
            exp_rd = model_mem[s][ix];
        end
        @(negedge clk);                       // RVALID cycle
        chk("rv_pulse", 32'(rv[s]), 32'd1);
        chk("rv_gnt", 32'(gnt[s]), 32'd0);
        chk(w ? "write_ack_data" : "read_data", rdat[s], exp_rd);
        @(negedge clk);                       // RECOVER cycle
        chk("recover_rv", 32'(rv[s]), 32'd0);
        chk("recover_data", rdat[s], 32'd0);
        chk("recover_busy", 32'(bsy[s]), 32'd1);
        @(negedge clk);                       // back in IDLE
        chk("idle_busy", 32'(bsy[s]), 32'd0);
    endtask

    // Holds req high for a fixed window. Checks the pulse pattern of back-to-back accesses.
    task automatic held_req(input int s, input logic [31:0] a, input int n_acc);
        int period;
        int n_gnt;
        int n_rv;
        period = 4 + lat_of[s];
        n_gnt  = 0;
        n_rv   = 0;
        @(negedge clk);
        req[s] = 1'b1; we[s] = 1'b0; adr[s] = a; be[s] = 4'hF; wdat[s] = 32'd0;
        for (int k = 1; k <= n_acc * period; k++) begin
            @(negedge clk);
            if (k == n_acc * period) req[s] = 1'b0;
            chk("held_gnt", 32'(gnt[s]), 32'(k % period == 1));
            chk("held_rv", 32'(rv[s]), 32'(k % period == 2 + lat_of[s]));
            if (gnt[s]) n_gnt++;
            if (rv[s]) begin
                n_rv++;
                chk("held_rdata", rdat[s], model_mem[s][idx_of(a)]);
            end
        end
        chk("held_gnt_count", 32'(n_gnt), 32'(n_acc));
        chk("held_rv_count", 32'(n_rv), 32'(n_acc));
        @(negedge clk);
        chk("held_idle", 32'(bsy[s]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] base_adr [8];
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; adr[s] = 32'd0; we[s] = 1'b0; be[s] = 4'd0; wdat[s] = 32'd0;
        end

        // Reset values.
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_gnt", 32'(gnt[s]), 32'd0);
            chk("rst_rv", 32'(rv[s]), 32'd0);
            chk("rst_data", rdat[s], 32'd0);
            chk("rst_busy", 32'(bsy[s]), 32'd0);
        end
        repeat (2) @(negedge clk);
        res = 1'b0;

        // Full-word write, then read back.
        access(0, 1'b1, 32'h10, 4'hF, 32'hCAFEBABE);
        access(0, 1'b0, 32'h10, 4'hF, 32'h0);
        chk("t1_model", model_mem[0][4], 32'hCAFEBABE);

        // Byte-enabled merge.
        access(0, 1'b1, 32'h14, 4'hF, 32'h11223344);
        access(0, 1'b1, 32'h14, 4'b0101, 32'hAABBCCDD);
        access(0, 1'b0, 32'h14, 4'hF, 32'h0);
        chk("t2_model", model_mem[0][5], 32'h11BB33DD);

        // A be=0000 write leaves the word unchanged.
        access(0, 1'b1, 32'h14, 4'h0, 32'hFFFFFFFF);
        access(0, 1'b0, 32'h14, 4'hF, 32'h0);

        // Address wrap and ignored offset bits.
        access(0, 1'b1, 32'h1000, 4'hF, 32'h5);
        access(0, 1'b0, 32'h0, 4'hF, 32'h0);
        access(0, 1'b0, 32'h13, 4'hF, 32'h0);

        // Continuously held req.
        held_req(0, 32'h10, 3);
        held_req(1, 32'h10, 0 + 1);

        // Async reset during the WAIT cycle of a write.
        access(0, 1'b1, 32'h20, 4'hF, 32'h0);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; be[0] = 4'hF; wdat[0] = 32'hDEADBEEF;
        @(negedge clk);
        req[0] = 1'b0;
        @(posedge clk);
        #2;
        res = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt[0]), 32'd0);
        chk("arst_rv", 32'(rv[0]), 32'd0);
        chk("arst_data", rdat[0], 32'd0);
        chk("arst_busy", 32'(bsy[0]), 32'd0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        access(0, 1'b0, 32'h20, 4'hF, 32'h0);

        // LATENCY=0: write ack, then read back.
        access(1, 1'b1, 32'h40, 4'hF, 32'h12345678);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0);
        held_req(1, 32'h40, 3);

        // Random accesses over a small address set, on both instances.
        for (int j = 0; j < 8; j++) base_adr[j] = 32'(j * 4 + 32'h100);
        for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < 8; j++) access(s, 1'b1, base_adr[j], 4'hF, $urandom);
            for (int n = 0; n < 30; n++) begin
                logic [31:0] a;
                a = base_adr[$urandom_range(0, 7)];
                a = {20'($urandom), a[11:2], 2'($urandom)};
                access(s, 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
